// File: rtl/matrix_drain_pkg.sv
// ----------------------------------------------------------------------------
// matrix_pkg
//   Shared definitions for the 4x4 result drain: drain FSM states, matrix
//   geometry constants and the (row, col) -> linear index helper. The helper
//   is also imported by the testbench.
// ----------------------------------------------------------------------------
package matrix_pkg;

    localparam int N         = 4;
    localparam int NUM_WORDS = N * N;
    localparam int IDX_W     = 4;
    localparam int RC_W      = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

    // Row-major position of element (row, col) in the snapshot buffer.
    function automatic logic [IDX_W-1:0] rc2idx(input logic [RC_W-1:0] row,
                                                 input logic [RC_W-1:0] col);
        return IDX_W'(int'(row) * N + int'(col));
    endfunction

endpackage

// File: rtl/matrix_drain_if.sv
// ----------------------------------------------------------------------------
// matrix_drain_if
//   Valid/ready result stream leaving the drain.
//   out_data  : streamed word
//   out_valid : data/index/last valid
//   out_ready : consumer accepts when valid && ready
//   out_index : linear index 0..15 of the current word
//   out_last  : high with index 15
//   master = drain side, slave = consumer side.
// ----------------------------------------------------------------------------
interface matrix_drain_if
    import matrix_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_index;
    logic             out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_index,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/matrix_drain_addr.sv
// ----------------------------------------------------------------------------
// matrix_drain_addr
//   Combinational map from stream index to snapshot buffer select. The buffer
//   is stored row-major; with MATRIX_DRAIN_TRANSPOSE_EN defined the stream
//   walks it column-major instead.
//   i_idx : linear stream index 0..15
//   o_sel : buffer entry to present
//   Macro: MATRIX_DRAIN_TRANSPOSE_EN (column-major order when defined)
// ----------------------------------------------------------------------------
module matrix_drain_addr
    import matrix_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    output logic [IDX_W-1:0] o_sel
);

    logic [RC_W-1:0] w_hi;
    logic [RC_W-1:0] w_lo;

    assign w_hi = i_idx[IDX_W-1:RC_W];   // k / N
    assign w_lo = i_idx[RC_W-1:0];       // k % N

`ifdef MATRIX_DRAIN_TRANSPOSE_EN
    // row = k % N, col = k / N
    assign o_sel = rc2idx(w_lo, w_hi);
`else
    // row = k / N, col = k % N (identity on the row-major buffer)
    assign o_sel = rc2idx(w_hi, w_lo);
`endif

endmodule

// File: rtl/matrix_drain.sv
// ----------------------------------------------------------------------------
// matrix_drain
//   Snapshots the 16 aggregator result words on a load pulse and streams them
//   out one per accepted handshake, so the aggregator can start the next tile
//   while the previous one drains.
//   clk, rst   : clock, synchronous active-high reset
//   load       : one-cycle pulse, r11..r44 valid this cycle
//   r11..r44   : result matrix, rRC = row R, column C
//   out_if     : valid/ready stream (data, index, last)
//   busy       : high while streaming
//   overrun    : sticky, a load arrived mid-stream and was dropped
//   Macro: MATRIX_DRAIN_TRANSPOSE_EN selects column-major stream order.
// ----------------------------------------------------------------------------
module matrix_drain
    import matrix_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] r11, r12, r13, r14,
    input  logic [WIDTH-1:0] r21, r22, r23, r24,
    input  logic [WIDTH-1:0] r31, r32, r33, r34,
    input  logic [WIDTH-1:0] r41, r42, r43, r44,
    matrix_drain_if.master   out_if,
    output logic             busy,
    output logic             overrun
);

    drain_state_t                    r_state;
    drain_state_t                    w_state_nxt;
    logic [NUM_WORDS-1:0][WIDTH-1:0] r_buf;
    logic [NUM_WORDS-1:0][WIDTH-1:0] w_r_in;
    logic [IDX_W-1:0]                r_idx;
    logic [IDX_W-1:0]                w_sel;
    logic                            w_stream;
    logic                            w_hs;
    logic                            w_at_end;
    logic                            w_take;

    // Entry 0 is r11, entries run row-major up to r44.
    assign w_r_in = {r44, r43, r42, r41,
                     r34, r33, r32, r31,
                     r24, r23, r22, r21,
                     r14, r13, r12, r11};

    assign w_stream = (r_state == STREAM);
    // out_valid is exactly w_stream, so the handshake needs only state+ready.
    assign w_hs     = w_stream && out_if.out_ready;
    assign w_at_end = (r_idx == IDX_W'(NUM_WORDS - 1));
    // A load is taken from IDLE, or back-to-back as the last word is accepted.
    assign w_take   = load && (!w_stream || (w_hs && w_at_end));

    matrix_drain_addr u_addr (
        .i_idx (r_idx),
        .o_sel (w_sel)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (load) w_state_nxt = STREAM;
            STREAM:  if (w_hs && w_at_end && !load) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs: all derived from registered state/index/buffer.
    always_comb begin
        out_if.out_valid = w_stream;
        out_if.out_index = r_idx;
        out_if.out_last  = w_stream && w_at_end;
        // Gate data so it reads zero out of reset, when the buffer is unknown.
        out_if.out_data  = w_stream ? r_buf[w_sel] : '0;
        busy             = w_stream;
    end

    // Snapshot buffer, no reset needed.
    always_ff @(posedge clk) begin
        if (w_take) r_buf <= w_r_in;
    end

    // Index counter and sticky overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            overrun <= 1'b0;
        end else begin
            if (w_take)
                r_idx <= '0;
            else if (w_hs && !w_at_end)
                r_idx <= r_idx + 1'b1;
            else if (w_hs)
                r_idx <= '0;   // tile finished, park at 0 for the next one

            if (load && w_stream && !w_take)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_matrix_drain.sv
module tb_matrix_drain;
    import matrix_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] m [N][N];
    logic             busy;
    logic             overrun;

    int               total = 0;
    int               bad   = 0;
    logic [WIDTH-1:0] q [$];

    matrix_drain_if #(.WIDTH(WIDTH)) sif ();

    matrix_drain #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .r11 (m[0][0]), .r12 (m[0][1]), .r13 (m[0][2]), .r14 (m[0][3]),
        .r21 (m[1][0]), .r22 (m[1][1]), .r23 (m[1][2]), .r24 (m[1][3]),
        .r31 (m[2][0]), .r32 (m[2][1]), .r33 (m[2][2]), .r34 (m[2][3]),
        .r41 (m[3][0]), .r42 (m[3][1]), .r43 (m[3][2]), .r44 (m[3][3]),
        .out_if  (sif),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // base==0: rRC = 0x10*R + C; otherwise base + row-major position.
    task automatic set_tile(input logic [WIDTH-1:0] base);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[r][c] = (base == 0) ? WIDTH'(16 * (r + 1) + (c + 1))
                                      : base + WIDTH'(r * N + c);
    endtask

    // Expected stream order for the tile currently on the inputs.
    task automatic push_tile();
        for (int k = 0; k < NUM_WORDS; k++) begin
`ifdef MATRIX_DRAIN_TRANSPOSE_EN
            q.push_back(m[k % N][k / N]);
`else
            q.push_back(m[k / N][k % N]);
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; sif.out_ready = 1'b0;
        set_tile(0);
        tick(); tick();
        rst = 1'b0;
        total++; if (sif.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", sif.out_valid); end
        total++; if (sif.out_index !== 4'd0) begin bad++; $display("FAIL reset_index got=%0d exp=0", sif.out_index); end
        total++; if (sif.out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", sif.out_last); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        total++; if (sif.out_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", sif.out_data); end
        // out_ready is ignored in IDLE
        sif.out_ready = 1'b1; tick();
        total++; if (sif.out_valid !== 1'b0) begin bad++; $display("FAIL idle_ready_valid got=%b exp=0", sif.out_valid); end
    endtask

    task automatic test_basic();
        int cnt = 0;
        int cyc = 0;
        set_tile(0); q.delete(); push_tile();
        load = 1'b1; sif.out_ready = 1'b1;
        tick();
        load = 1'b0;
        total++; if (sif.out_valid !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL basic_latency valid=%b busy=%b exp=1/1", sif.out_valid, busy); end
        while (cnt < NUM_WORDS && cyc < 100) begin
            sif.out_ready = 1'b1;
            if (sif.out_valid) begin
                total++;
                if (sif.out_data !== q[0] || sif.out_index !== IDX_W'(cnt) || sif.out_last !== (cnt == 15)) begin
                    bad++; $display("FAIL basic_word k=%0d data=%h idx=%0d last=%b exp data=%h last=%b",
                                    cnt, sif.out_data, sif.out_index, sif.out_last, q[0], (cnt == 15));
                end
                void'(q.pop_front()); cnt++;
            end
            tick(); cyc++;
        end
        total++; if (cnt !== NUM_WORDS) begin bad++; $display("FAIL basic_count got=%0d exp=16", cnt); end
        total++; if (busy !== 1'b0 || sif.out_valid !== 1'b0 || sif.out_last !== 1'b0) begin
            bad++; $display("FAIL basic_done busy=%b valid=%b last=%b exp=0/0/0", busy, sif.out_valid, sif.out_last); end
    endtask

    task automatic test_backpressure();
        int cnt = 0;
        int cyc = 0;
        logic [WIDTH-1:0] last_word = '0;
        set_tile(0); q.delete(); push_tile();
        load = 1'b1; tick(); load = 1'b0;
        while (cnt < NUM_WORDS && cyc < 200) begin
            sif.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (sif.out_valid) begin
                // Compared against the queue head every valid cycle, so a
                // held word must stay identical until it is accepted.
                total++;
                if (sif.out_data !== q[0] || sif.out_index !== IDX_W'(cnt) || sif.out_last !== (cnt == 15)) begin
                    bad++; $display("FAIL bp_word k=%0d data=%h idx=%0d last=%b exp data=%h last=%b",
                                    cnt, sif.out_data, sif.out_index, sif.out_last, q[0], (cnt == 15));
                end
                if (sif.out_ready) begin last_word = q.pop_front(); cnt++; end
            end
            tick(); cyc++;
        end
        total++; if (cnt !== NUM_WORDS || last_word !== 32'h44) begin
            bad++; $display("FAIL bp_count got=%0d last=%h exp=16 last=44", cnt, last_word); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_done busy=%b exp=0", busy); end
    endtask

    task automatic test_overrun();
        int cnt = 0;
        int cyc = 0;
        bit sent = 0;
        bit chk = 0;
        set_tile(0); q.delete(); push_tile();
        load = 1'b1; tick(); load = 1'b0;
        while (cnt < NUM_WORDS && cyc < 100) begin
            load = 1'b0;
            sif.out_ready = 1'b1;
            if (sent && !chk) begin
                chk = 1;
                total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", overrun); end
            end
            if (sif.out_valid) begin
                if (cnt == 5 && !sent) begin set_tile(32'hB000); load = 1'b1; sent = 1; end
                total++;
                if (sif.out_data !== q[0] || sif.out_index !== IDX_W'(cnt)) begin
                    bad++; $display("FAIL ovr_word k=%0d data=%h idx=%0d exp data=%h", cnt, sif.out_data, sif.out_index, q[0]);
                end
                void'(q.pop_front()); cnt++;
            end
            tick(); cyc++;
        end
        load = 1'b0;
        total++; if (cnt !== NUM_WORDS) begin bad++; $display("FAIL ovr_count got=%0d exp=16", cnt); end
        total++; if (overrun !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL ovr_sticky overrun=%b busy=%b exp=1/0", overrun, busy); end
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        int cyc = 0;
        set_tile(0); q.delete(); push_tile();
        load = 1'b1; tick(); load = 1'b0;
        sif.out_ready = 1'b1;
        while (cnt < 7 && cyc < 100) begin
            if (sif.out_valid) begin void'(q.pop_front()); cnt++; end
            tick(); cyc++;
        end
        total++; if (sif.out_index !== 4'd7 || sif.out_valid !== 1'b1) begin
            bad++; $display("FAIL rmid_pre idx=%0d valid=%b exp=7/1", sif.out_index, sif.out_valid); end
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if (sif.out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || sif.out_index !== 4'd0) begin
            bad++; $display("FAIL rmid_abort valid=%b busy=%b ovr=%b idx=%0d exp=0/0/0/0",
                            sif.out_valid, busy, overrun, sif.out_index); end
        tick();
        total++; if (sif.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_quiet valid=%b exp=0", sif.out_valid); end
        set_tile(32'hC000); q.delete(); push_tile();
        load = 1'b1; tick(); load = 1'b0;
        cnt = 0; cyc = 0;
        while (cnt < NUM_WORDS && cyc < 100) begin
            if (sif.out_valid) begin
                total++;
                if (sif.out_data !== q[0] || sif.out_index !== IDX_W'(cnt) || sif.out_last !== (cnt == 15)) begin
                    bad++; $display("FAIL rmid_word k=%0d data=%h idx=%0d last=%b exp data=%h",
                                    cnt, sif.out_data, sif.out_index, sif.out_last, q[0]);
                end
                void'(q.pop_front()); cnt++;
            end
            tick(); cyc++;
        end
        total++; if (cnt !== NUM_WORDS || busy !== 1'b0) begin
            bad++; $display("FAIL rmid_count got=%0d busy=%b exp=16/0", cnt, busy); end
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        int cyc = 0;
        int bubbles = 0;
        set_tile(0); q.delete(); push_tile();
        load = 1'b1; tick(); load = 1'b0;
        sif.out_ready = 1'b1;
        while (cnt < 2 * NUM_WORDS && cyc < 200) begin
            load = 1'b0;
            if (!sif.out_valid) bubbles++;
            else begin
                if (cnt == 15) begin set_tile(32'hB000); load = 1'b1; push_tile(); end
                total++;
                if (sif.out_data !== q[0] || sif.out_index !== IDX_W'(cnt % 16) || sif.out_last !== (cnt % 16 == 15)) begin
                    bad++; $display("FAIL b2b_word k=%0d data=%h idx=%0d last=%b exp data=%h last=%b",
                                    cnt, sif.out_data, sif.out_index, sif.out_last, q[0], (cnt % 16 == 15));
                end
                void'(q.pop_front()); cnt++;
            end
            tick(); cyc++;
        end
        load = 1'b0;
        total++; if (cnt !== 2 * NUM_WORDS || bubbles !== 0) begin
            bad++; $display("FAIL b2b_count got=%0d bubbles=%0d exp=32/0", cnt, bubbles); end
        total++; if (overrun !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL b2b_flags overrun=%b busy=%b exp=0/0", overrun, busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_drain.md
Name: matrix_drain

Overview:
- Downstream of the 4x4 result aggregator.
- On a load pulse, snapshots the 16 assembled result words r11..r44.
- Streams them out one word per accepted handshake over a valid/ready interface, with index and last markers.
- Decouples the systolic compute pipeline from the slower result consumer (bus writer / memory store), so the aggregator can start the next tile while the previous one drains.

Parameters:
- WIDTH, 32, data word width; must match the aggregator output width.
- N, 4, matrix dimension; fixed at 4 in this revision, parameterised for the package only.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- load  in  1  one-cycle pulse; all 16 r inputs valid this cycle
- r11..r44  in  WIDTH each (16 ports)  result matrix, rRC = row R, column C
- out_data  out  WIDTH  current streamed word
- out_valid  out  1  out_data/out_index/out_last valid
- out_ready  in  1  consumer accepts the word when valid and ready are both high
- out_index  out  4  linear index of current word, 0..15
- out_last  out  1  high with index 15
- busy  out  1  high while in STREAM
- overrun  out  1  sticky; a load arrived while busy and was dropped

Behaviour:
- Reset (rst=1 at a clk edge) gives:
  - state=IDLE, out_valid=0, out_index=0, out_last=0, busy=0, overrun=0.
  - out_data=0; snapshot buffer contents are don't-care.
- Reset mid-stream aborts immediately. No further words are presented and the in-flight tile is lost.
- States are IDLE and STREAM.
- IDLE:
  - load=1 copies all 16 inputs into the internal buffer, sets index=0 and moves to STREAM.
  - From the next cycle: out_valid=1, busy=1, out_data=buffer[0].
  - Latency is 1 cycle from load to the first valid word.
- STREAM:
  - Handshake is out_valid && out_ready at a clk edge.
  - On a handshake with index<15, index increments and out_data updates next cycle.
  - Without a handshake, out_data, out_index and out_last hold stable. valid never drops until accepted.
  - out_last = (index==15), asserted combinationally from the registered index.
- Handshake at index 15:
  - With load=0 in that cycle: go to IDLE; out_valid=0 and busy=0 next cycle.
  - With load=1 in the same cycle: the load is accepted back-to-back. The buffer is reloaded, index=0, the block stays in STREAM, and out_valid stays high with the new word 0 next cycle. overrun is not set.
- load=1 in STREAM at any other time is ignored: the buffer is unchanged and overrun is set to 1, cleared only by rst.
- Linear order, default row-major: index k maps to row k/4, column k%4. Index 0 is r11, 1 is r12, 4 is r21, 15 is r44.
- out_ready is ignored in IDLE. No combinational path from out_ready to out_valid.
- Index counter has 4 bits and never wraps internally; 15 is terminal.

Optional Feature:
- Macro: MATRIX_DRAIN_TRANSPOSE_EN.
- Defined: order is column-major; index k maps to row k%4, column k/4. Index 1 is r21, 4 is r12, 15 is r44. All handshake and timing behaviour is unchanged.
- Undefined: row-major as above. No extra logic.

Decomposition:
- Shared package matrix_pkg holds:
  - the drain state enum (IDLE, STREAM);
  - constant N=4 and constant NUM_WORDS=16;
  - index width constant IDX_W=4;
  - a function mapping (row, col) to linear index, also used by verification.
- One sub-module is natural: matrix_drain_addr. It is combinational and maps linear index to the buffer select, with the transpose macro applied there.

Test Plan:
- Basic row-major order: reset, then load with rRC=0x10*R+C (r11=0x11 … r44=0x44), out_ready held 1. Expected response:
  - First valid one cycle after load.
  - 16 consecutive words 0x11,0x12,0x13,0x14,0x21…0x44.
  - out_last only on 0x44.
  - busy falls the cycle after.
- Backpressure: same data; out_ready toggles 1,0,0,1 repeating. Each word is held stable while ready=0, with no skips or duplicates. Total 16 handshakes, last = 0x44.
- Overrun: load tile A, then a second load at index 5 with tile B=0xB000+k. overrun=1 and stays 1. The stream continues with tile A values only, then returns to IDLE.
- Back-to-back: load tile A, and pulse load with tile B in the cycle index 15 is accepted. No bubble: the word after 0x44 is B's r11. overrun=0. 32 words total.
- Reset mid-stream: rst=1 at index 7. Next cycle out_valid=0, busy=0, overrun=0, index=0. A new load afterwards streams correctly from index 0.
- With MATRIX_DRAIN_TRANSPOSE_EN defined: basic data with ready=1 yields 0x11,0x21,0x31,0x41,0x12…0x44, with out_last on 0x44.
